// File: rtl/tdc_reg_arbiter_if.sv
// AXI4-Lite master bundle between tdc_reg_arbiter and the tdc S00_AXI register port.
interface tdc_reg_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/tdc_reg_arbiter.sv
// Round-robin arbiter serialising N_REQ single-word requesters onto one AXI4-Lite master port.
// Optional TDC_ARB_ADDR_CHECK_EN: misaligned/out-of-range addresses answered locally with SLVERR.
module tdc_reg_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_wr,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic [1:0]              rsp_resp,
  tdc_reg_arbiter_if.master       m_axi
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW    = IDX_W + 1;

  typedef enum logic [2:0] {IDLE, GRANT, WR, BWAIT, RD, RWAIT, RESP} state_t;

  state_t                         state_q, state_d;
  logic [IDX_W-1:0]               rr_q, rr_d, idx_q, idx_d, pick_idx;
  logic                           pick_vld;
  logic [CW-1:0]                  rr_j;
  logic                           wr_q, wr_d;
  logic [ADDR_W-1:0]              addr_q, addr_d;
  logic [DATA_W-1:0]              wdata_q, wdata_d, rdata_d;
  logic [1:0]                     resp_d;
  logic [N_REQ-1:0]               req_ready_d, rsp_valid_d;
  logic                           awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                           arvalid_q, arvalid_d, rready_q, rready_d;
  logic                           addr_bad;
  logic [N_REQ-1:0][ADDR_W-1:0]   req_addr_a;
  logic [N_REQ-1:0][DATA_W-1:0]   req_wdata_a;

  assign req_addr_a  = req_addr;
  assign req_wdata_a = req_wdata;

`ifdef TDC_ARB_ADDR_CHECK_EN
  assign addr_bad = (addr_q[1:0] != 2'b00) || (32'(addr_q) >= 32'd16);
`else
  assign addr_bad = 1'b0;
`endif

  // First requester at or above the rr pointer, wrapping at N_REQ.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    rr_j     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      rr_j = {1'b0, rr_q} + CW'(k);
      if (rr_j >= CW'(N_REQ)) rr_j = rr_j - CW'(N_REQ);
      if (!pick_vld && req_valid[rr_j[IDX_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = rr_j[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    idx_d       = idx_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rdata_d     = rsp_rdata;
    resp_d      = rsp_resp;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    case (state_q)
      IDLE: if (pick_vld) begin
        idx_d                 = pick_idx;
        wr_d                  = req_wr[pick_idx];
        addr_d                = req_addr_a[pick_idx];
        wdata_d               = req_wdata_a[pick_idx];
        req_ready_d[pick_idx] = 1'b1;
        state_d               = GRANT;
      end
      GRANT: begin
        if (addr_bad) begin
          resp_d  = 2'b10;
          rdata_d = '0;
          state_d = RESP;
        end else if (wr_q) begin
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = WR;
        end else begin
          arvalid_d = 1'b1;
          state_d   = RD;
        end
      end
      WR: begin
        // aw and w retire independently; leave once both have handshaken.
        awvalid_d = awvalid_q & ~m_axi.awready;
        wvalid_d  = wvalid_q & ~m_axi.wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = BWAIT;
        end
      end
      BWAIT: if (m_axi.bvalid) begin
        resp_d   = m_axi.bresp;
        rdata_d  = '0;
        bready_d = 1'b0;
        state_d  = RESP;
      end
      RD: if (m_axi.arready) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        state_d   = RWAIT;
      end
      RWAIT: if (m_axi.rvalid) begin
        rdata_d  = m_axi.rdata;
        resp_d   = m_axi.rresp;
        rready_d = 1'b0;
        state_d  = RESP;
      end
      RESP: begin
        rsp_valid_d[idx_q] = 1'b1;
        rr_d    = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      idx_q     <= idx_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rdata_d;
      rsp_resp  <= resp_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
    end
  end

  // Address/data come straight from the latch registers, which only move in IDLE.
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = '1;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;
endmodule
